// File: rtl/conv_row_scheduler.sv
// ---------------------------------------------------------------------------
// conv_row_scheduler
//
// Row-level sequencer in front of a combinational 3-row convolution
// datapath. Image rows arrive one per valid/ready handshake into a 3-row
// line buffer that drives the datapath window directly. Zero rows give the
// top padding (buffer cleared on start) and the bottom padding (a single
// FLUSH shift per frame). For every output row the window is held stable
// for CONV_LAT cycles, the datapath result is captured, and the captured
// row is offered downstream with its row index.
//
// The kernel register feeding the datapath lives here as well and may only
// be loaded while the scheduler is idle.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a frame (honoured only while idle)
//   busy, done         busy outside IDLE; done pulses once per frame
//   kernel_load/_in    capture a 3x3 kernel, element [i][j] at (i*3+j)*KER_W
//   kernel_out         registered kernel to the datapath
//   row_valid/_ready   input row handshake, row_data pixel c at c*PIX_W
//   win_data           3-row window, row k (0 = top) at k*row width
//   win_valid          window stable and being evaluated
//   conv_result        datapath result row
//   out_valid/_ready   result row handshake
//   out_data, out_row  captured result row and its row index
// ---------------------------------------------------------------------------
module conv_row_scheduler #(
    parameter int HEIGHT_OF_KERNEL = 3,
    parameter int WIDTH_OF_IMAGE   = 4,
    parameter int HEIGHT_OF_IMAGE  = 3,
    parameter int PIX_W            = 8,
    parameter int KER_W            = 16,
    parameter int RES_W            = 32,
    parameter int CONV_LAT         = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  kernel_load,
    input  logic [9*KER_W-1:0]                    kernel_in,
    output logic [9*KER_W-1:0]                    kernel_out,
    input  logic                                  row_valid,
    output logic                                  row_ready,
    input  logic [WIDTH_OF_IMAGE*PIX_W-1:0]       row_data,
    output logic [3*WIDTH_OF_IMAGE*PIX_W-1:0]     win_data,
    output logic                                  win_valid,
    input  logic [WIDTH_OF_IMAGE*RES_W-1:0]       conv_result,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH_OF_IMAGE*RES_W-1:0]       out_data,
    output logic [$clog2(HEIGHT_OF_IMAGE+1)-1:0]  out_row
);

    localparam int ROW_W  = WIDTH_OF_IMAGE * PIX_W;
    localparam int ROWS_W = $clog2(HEIGHT_OF_IMAGE + 1);
    localparam int CNT_W  = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    localparam logic [ROWS_W-1:0] LAST_ROW = ROWS_W'(HEIGHT_OF_IMAGE - 1);
    localparam logic [ROWS_W-1:0] ALL_ROWS = ROWS_W'(HEIGHT_OF_IMAGE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CONV_LAT - 1);

    // Elaboration-time parameter checks.
    if (HEIGHT_OF_KERNEL != 3) begin : g_bad_kernel_height
        $error("conv_row_scheduler: only HEIGHT_OF_KERNEL == 3 is supported");
    end
    if (HEIGHT_OF_IMAGE < 1) begin : g_bad_image_height
        $error("conv_row_scheduler: HEIGHT_OF_IMAGE must be at least 1");
    end
    if (CONV_LAT < 1) begin : g_bad_conv_lat
        $error("conv_row_scheduler: CONV_LAT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_CONV,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                                 r_state;
    // Element [0] is the top row and sits in the low bits, so the packed
    // array maps straight onto the window bus.
    logic [2:0][ROW_W-1:0]                  r_buf;
    logic [9*KER_W-1:0]                     r_kernel;
    logic [WIDTH_OF_IMAGE*RES_W-1:0]        r_out_data;
    logic [ROWS_W-1:0]                      r_out_row;
    logic [ROWS_W-1:0]                      r_rows_in;
    logic [CNT_W-1:0]                       r_cnt;
    logic                                   r_busy;
    logic                                   r_done;
    logic                                   r_row_ready;
    logic                                   r_win_valid;
    logic                                   r_out_valid;

    logic                                   w_first_row;
    logic                                   w_row_hs;

    assign w_first_row = (r_rows_in == '0);
    assign w_row_hs    = row_valid && r_row_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_kernel    <= '0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_rows_in   <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_row_ready <= 1'b0;
            r_win_valid <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the EMIT->DONE edge raises it.
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (kernel_load) begin
                        r_kernel <= kernel_in;
                    end
                    if (start) begin
                        // Cleared buffer supplies the top padding row.
                        r_buf       <= '0;
                        r_rows_in   <= '0;
                        r_out_row   <= '0;
                        r_busy      <= 1'b1;
                        r_row_ready <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (w_row_hs) begin
                        r_buf     <= {row_data, r_buf[2], r_buf[1]};
                        r_rows_in <= r_rows_in + 1'b1;
                        // The first row of a multi-row frame only primes the
                        // buffer; a one-row frame needs its bottom pad first.
                        if (w_first_row && HEIGHT_OF_IMAGE == 1) begin
                            r_row_ready <= 1'b0;
                            r_state     <= S_FLUSH;
                        end else if (!w_first_row) begin
                            r_row_ready <= 1'b0;
                            r_win_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_CONV;
                        end
                    end
                end

                S_FLUSH: begin
                    // Bottom padding: shift in a zero row, once per frame.
                    r_buf       <= {{ROW_W{1'b0}}, r_buf[2], r_buf[1]};
                    r_win_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_CONV;
                end

                S_CONV: begin
                    // Buffer frozen; sample the datapath once it has had
                    // CONV_LAT full cycles with a stable window.
                    if (r_cnt == CNT_LAST) begin
                        r_out_data  <= conv_result;
                        r_win_valid <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_row   <= r_out_row + 1'b1;
                        if (r_out_row == LAST_ROW) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (r_rows_in == ALL_ROWS) begin
                            // All rows are in; the next window needs the pad.
                            r_state <= S_FLUSH;
                        end else begin
                            r_row_ready <= 1'b1;
                            r_state     <= S_FILL;
                        end
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_row_ready <= 1'b0;
                    r_win_valid <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign kernel_out = r_kernel;
    assign row_ready  = r_row_ready;
    assign win_data   = r_buf;
    assign win_valid  = r_win_valid;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_row    = r_out_row;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for conv_row_scheduler. Two instances: a 3-row frame with CONV_LAT=1
// and a 1-row frame with CONV_LAT=3. The convolution datapath is modelled
// here as a plain 3x3 multiply-accumulate (zero outside the row edges);
// expected rows come from the source frame and kernel held by the bench.
// ---------------------------------------------------------------------------
module tb_conv_row_scheduler;

    localparam int W = 4, PW = 8, KW = 16, RW = 32, H = 3;
    localparam int ROW_W = W * PW;

    typedef logic [9*KW-1:0]    ker_t;
    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [3*ROW_W-1:0] win_t;
    typedef logic [W*RW-1:0]    res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: H=3, CONV_LAT=1
    logic start, busy, done, kernel_load, row_valid, row_ready, win_valid, out_valid, out_ready;
    ker_t kernel_in, kernel_out;
    row_t row_data;
    win_t win_data;
    res_t conv_result, out_data;
    logic [1:0] out_row;

    // Instance B: H=1, CONV_LAT=3
    logic start1, busy1, done1, kernel_load1, row_valid1, row_ready1, win_valid1, out_valid1, out_ready1;
    ker_t kernel_in1, kernel_out1;
    row_t row_data1;
    win_t win_data1;
    res_t conv_result1, out_data1;
    logic [0:0] out_row1;

    conv_row_scheduler #(.HEIGHT_OF_KERNEL(3), .WIDTH_OF_IMAGE(W), .HEIGHT_OF_IMAGE(H),
        .PIX_W(PW), .KER_W(KW), .RES_W(RW), .CONV_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .kernel_load(kernel_load), .kernel_in(kernel_in), .kernel_out(kernel_out),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .win_data(win_data), .win_valid(win_valid), .conv_result(conv_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row));

    conv_row_scheduler #(.HEIGHT_OF_KERNEL(3), .WIDTH_OF_IMAGE(W), .HEIGHT_OF_IMAGE(1),
        .PIX_W(PW), .KER_W(KW), .RES_W(RW), .CONV_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .kernel_load(kernel_load1), .kernel_in(kernel_in1), .kernel_out(kernel_out1),
        .row_valid(row_valid1), .row_ready(row_ready1), .row_data(row_data1),
        .win_data(win_data1), .win_valid(win_valid1), .conv_result(conv_result1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_row(out_row1));

    // 3x3 convolution over a 3-row window, zero beyond the left/right edges.
    function automatic res_t conv(input ker_t k, input win_t w);
        res_t r = '0;
        for (int c = 0; c < W; c++) begin
            longint unsigned acc = 0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    int cc = c + j - 1;
                    if (cc >= 0 && cc < W)
                        acc += longint'(k[(i*3+j)*KW +: KW]) * longint'(w[i*ROW_W + cc*PW +: PW]);
                end
            end
            r[c*RW +: RW] = acc[RW-1:0];
        end
        return r;
    endfunction

    always_comb conv_result  = conv(kernel_out, win_data);
    always_comb conv_result1 = conv(kernel_out1, win_data1);

    int passed = 0, total = 0;

    row_t frame [H];
    res_t got_data[$];
    int   got_row[$];
    int   n_done, n_flush, n_winbad, n_stallbad, n_rrbad, n_held, rows_sent, timeout;

    function automatic row_t mkrow(input int a, input int b, input int c, input int d);
        return {PW'(d), PW'(c), PW'(b), PW'(a)};
    endfunction

    function automatic res_t mkres(input int a, input int b, input int c, input int d);
        return {RW'(d), RW'(c), RW'(b), RW'(a)};
    endfunction

    function automatic ker_t onehot(input int idx);
        ker_t k = '0;
        k[idx*KW +: KW] = 16'h0100;
        return k;
    endfunction

    // Window for output row r: source rows r-1, r, r+1, zero when out of range.
    function automatic win_t exp_win(input int r);
        win_t w = '0;
        for (int k = 0; k < 3; k++) begin
            int src = r - 1 + k;
            if (src >= 0 && src < H) w[k*ROW_W +: ROW_W] = frame[src];
        end
        return w;
    endfunction

    task automatic set_test_frame();
        frame[0] = mkrow(1, 2, 3, 4);
        frame[1] = mkrow(5, 6, 7, 8);
        frame[2] = mkrow(9, 10, 11, 255);
    endtask

    // Runs one frame on instance A, recording emitted rows and protocol
    // observations. stall_idx/stall_len hold out_ready low on one result.
    task automatic drive_frame(input ker_t k, input bit load, input int stall_idx,
                               input int stall_len, input bit rnd_ready, input bit kload_busy);
        int   cyc = 0, ri = 0, stall_left = stall_len;
        bit   holding = 0;
        res_t held = '0;
        logic [1:0] held_row = '0;
        got_data.delete(); got_row.delete();
        n_done = 0; n_flush = 0; n_winbad = 0; n_stallbad = 0; n_rrbad = 0; n_held = 0; timeout = 0;
        @(negedge clk);
        kernel_load = load; kernel_in = k; start = 1'b1;
        @(negedge clk);
        kernel_load = 1'b0; start = 1'b0;
        while (n_done == 0) begin
            if (cyc >= 300) begin timeout = 1; break; end
            cyc++;
            if (done) n_done++;
            if (busy && !row_ready && !win_valid && !out_valid && !done) n_flush++;
            if (win_valid && win_data !== exp_win(got_data.size())) n_winbad++;
            if (out_valid && row_ready) n_rrbad++;
            if (holding && (!out_valid || out_data !== held || out_row !== held_row)) n_stallbad++;
            row_valid = (ri < H);
            row_data  = (ri < H) ? frame[ri] : '0;
            if (out_valid && got_data.size() == stall_idx && stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            holding  = out_valid && !out_ready;
            held     = out_data;
            held_row = out_row;
            if (holding) n_held++;
            kernel_load = kload_busy && busy && !done;
            kernel_in   = kload_busy ? ~k : k;
            if (row_valid && row_ready) ri++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_row.push_back(int'(out_row));
            end
            @(negedge clk);
        end
        row_valid = 1'b0; out_ready = 1'b0; kernel_load = 1'b0;
        rows_sent = ri;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, row_ready, win_valid, out_valid} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {busy, done, row_ready, win_valid, out_valid});
        else passed++;
        total++;
        if (kernel_out !== '0 || win_data !== '0) $display("FAIL reset_kernel_win got %h / %h want 0", kernel_out, win_data);
        else passed++;
        total++;
        if (out_data !== '0 || out_row !== '0) $display("FAIL reset_out got %h row %0d want 0", out_data, out_row);
        else passed++;
        total++;
        if ({busy1, done1, row_ready1, win_valid1, out_valid1} !== 5'b0 || out_data1 !== '0)
            $display("FAIL reset_dut1 got flags %b data %h want 0", {busy1, done1, row_ready1, win_valid1, out_valid1}, out_data1);
        else passed++;
    endtask

    task automatic check_rows(input string name, input res_t e0, input res_t e1, input res_t e2);
        res_t exp[3];
        exp[0] = e0; exp[1] = e1; exp[2] = e2;
        total++;
        if (timeout != 0 || got_data.size() != H)
            $display("FAIL %s_count got %0d rows timeout %0d want %0d rows", name, got_data.size(), timeout, H);
        else passed++;
        for (int r = 0; r < H; r++) begin
            res_t g = 'x;
            int   gr = -1;
            if (r < got_data.size()) begin g = got_data[r]; gr = got_row[r]; end
            total++;
            if (g !== exp[r] || gr != r)
                $display("FAIL %s_row%0d got %h idx %0d want %h idx %0d", name, r, g, gr, exp[r], r);
            else passed++;
        end
    endtask

    task automatic test_center_kernel();
        set_test_frame();
        drive_frame(onehot(4), 1'b1, -1, 0, 1'b0, 1'b0);
        check_rows("center", mkres(256, 512, 768, 1024), mkres(1280, 1536, 1792, 2048),
                   mkres(2304, 2560, 2816, 65280));
        total++;
        if (n_done != 1 || n_winbad != 0 || rows_sent != H)
            $display("FAIL center_proto got done %0d winbad %0d rows %0d want 1 0 %0d", n_done, n_winbad, rows_sent, H);
        else passed++;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || kernel_out !== onehot(4))
            $display("FAIL center_after got busy %b done %b kernel %h want 0 0 %h", busy, done, kernel_out, onehot(4));
        else passed++;
    endtask

    task automatic test_top_select();
        set_test_frame();
        drive_frame(onehot(1), 1'b1, -1, 0, 1'b0, 1'b0);
        check_rows("top", mkres(0, 0, 0, 0), mkres(256, 512, 768, 1024), mkres(1280, 1536, 1792, 2048));
    endtask

    task automatic test_bottom_flush();
        set_test_frame();
        drive_frame(onehot(7), 1'b1, -1, 0, 1'b0, 1'b0);
        check_rows("bottom", mkres(1280, 1536, 1792, 2048), mkres(2304, 2560, 2816, 65280), mkres(0, 0, 0, 0));
        total++;
        if (n_flush != 1) $display("FAIL bottom_flush_once got %0d want 1", n_flush);
        else passed++;
    endtask

    task automatic test_backpressure();
        set_test_frame();
        drive_frame(onehot(4), 1'b1, 1, 5, 1'b0, 1'b0);
        check_rows("stall", mkres(256, 512, 768, 1024), mkres(1280, 1536, 1792, 2048),
                   mkres(2304, 2560, 2816, 65280));
        total++;
        if (n_held != 5 || n_stallbad != 0 || n_rrbad != 0)
            $display("FAIL stall_hold got held %0d unstable %0d ready_in_emit %0d want 5 0 0", n_held, n_stallbad, n_rrbad);
        else passed++;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            ker_t k;
            for (int i = 0; i < 9; i++) k[i*KW +: KW] = 16'($urandom);
            for (int r = 0; r < H; r++) frame[r] = row_t'($urandom);
            drive_frame(k, 1'b1, -1, 0, 1'b1, 1'b0);
            check_rows($sformatf("rand%0d", f), conv(k, exp_win(0)), conv(k, exp_win(1)), conv(k, exp_win(2)));
            total++;
            if (n_winbad != 0 || n_stallbad != 0 || n_flush != 1)
                $display("FAIL rand%0d_proto got winbad %0d unstable %0d flush %0d want 0 0 1", f, n_winbad, n_stallbad, n_flush);
            else passed++;
        end
    endtask

    // Single-row frame on instance B: state path encoded one digit per
    // distinct phase (1 FILL, 2 FLUSH, 3 CONV, 4 EMIT, 5 DONE).
    task automatic test_height1();
        int   path = 0, last = -1, cyc = 0, code, wv_cnt = 0, ngot = 0, gr = -1;
        res_t got = 'x;
        @(negedge clk);
        kernel_load1 = 1'b1; kernel_in1 = onehot(4); start1 = 1'b1;
        @(negedge clk);
        kernel_load1 = 1'b0; start1 = 1'b0;
        while (cyc < 100) begin
            cyc++;
            if (done1) code = 5;
            else if (out_valid1) code = 4;
            else if (win_valid1) code = 3;
            else if (row_ready1) code = 1;
            else if (busy1) code = 2;
            else code = 0;
            if (code == 3) wv_cnt++;
            if (code != last) begin path = path * 10 + code; last = code; end
            row_valid1 = 1'b1; row_data1 = mkrow(1, 2, 3, 4); out_ready1 = 1'b1;
            if (out_valid1) begin got = out_data1; ngot++; gr = int'(out_row1); end
            if (code == 5) break;
            @(negedge clk);
        end
        row_valid1 = 1'b0; out_ready1 = 1'b0;
        total++;
        if (path != 12345) $display("FAIL h1_path got %0d want 12345", path);
        else passed++;
        total++;
        if (got !== mkres(256, 512, 768, 1024) || ngot != 1 || gr != 0)
            $display("FAIL h1_result got %h n %0d idx %0d want %h n 1 idx 0", got, ngot, gr, mkres(256, 512, 768, 1024));
        else passed++;
        total++;
        if (wv_cnt != 3) $display("FAIL h1_conv_lat got %0d want 3", wv_cnt);
        else passed++;
        @(negedge clk);
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL h1_after got busy %b done %b want 0 0", busy1, done1);
        else passed++;
    endtask

    task automatic test_async_reset();
        int   cyc = 0, ri = 0;
        ker_t k;
        set_test_frame();
        @(negedge clk);
        kernel_load = 1'b1; kernel_in = onehot(4); start = 1'b1;
        @(negedge clk);
        kernel_load = 1'b0; start = 1'b0;
        while (!(win_valid && out_row == 2'd1) && cyc < 50) begin
            row_valid = (ri < H); row_data = (ri < H) ? frame[ri] : '0; out_ready = 1'b1;
            if (row_valid && row_ready) ri++;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= 50) $display("FAIL arst_reach_conv1 got timeout after %0d cycles want conv of row 1", cyc);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, row_ready, win_valid, out_valid} !== 5'b0)
            $display("FAIL arst_flags got %b want 00000", {busy, done, row_ready, win_valid, out_valid});
        else passed++;
        total++;
        if (kernel_out !== '0 || win_data !== '0 || out_data !== '0 || out_row !== '0)
            $display("FAIL arst_regs got kernel %h win %h out %h row %0d want 0", kernel_out, win_data, out_data, out_row);
        else passed++;
        row_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Fresh frame after reset; kernel_load is pulsed throughout busy.
        for (int i = 0; i < 9; i++) k[i*KW +: KW] = 16'($urandom_range(0, 1023));
        for (int r = 0; r < H; r++) frame[r] = row_t'($urandom);
        drive_frame(k, 1'b1, -1, 0, 1'b0, 1'b1);
        check_rows("arst_new", conv(k, exp_win(0)), conv(k, exp_win(1)), conv(k, exp_win(2)));
        total++;
        if (kernel_out !== k) $display("FAIL arst_kload_busy got %h want %h", kernel_out, k);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; kernel_load = 0; kernel_in = '0; row_valid = 0; row_data = '0; out_ready = 0;
        start1 = 0; kernel_load1 = 0; kernel_in1 = '0; row_valid1 = 0; row_data1 = '0; out_ready1 = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_center_kernel();
        test_top_select();
        test_bottom_flush();
        test_backpressure();
        test_random_frames();
        test_height1();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
